// File: rtl/dma_pkg.sv
// Shared DMA constants: data bus width, FIFO geometry, default watermarks and
// the transfer direction encoding.
package dma_pkg;

   localparam int unsigned DMA_DATA_W        = 32;
   localparam int unsigned DMA_FIFO_DEPTH    = 16;
   localparam int unsigned DMA_FIFO_ADDR_W   = $clog2(DMA_FIFO_DEPTH);
   localparam int unsigned DMA_FIFO_AF_LEVEL = 12;
   localparam int unsigned DMA_FIFO_AE_LEVEL = 4;

   typedef enum logic {
      FIFO_TO_RAM = 1'b0,
      RAM_TO_FIFO = 1'b1
   } dma_dir_e;

endpackage

// File: rtl/dma_fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port and one registered read
// port whose output register holds its value when no read is requested.
module dma_fifo_mem
   import dma_pkg::*;
#(
   parameter int unsigned DATA_W = DMA_DATA_W,
   parameter int unsigned DEPTH  = DMA_FIFO_DEPTH,
   parameter int unsigned ADDR_W = DMA_FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   // Storage needs no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/dma_fifo.sv
// Synchronous word FIFO between the DMA engine and the SD data-line stage.
// Holds pointers, level and registered status/error flags; storage is in dma_fifo_mem.
module dma_fifo
   import dma_pkg::*;
#(
   parameter int unsigned DATA_W   = DMA_DATA_W,
   parameter int unsigned DEPTH    = DMA_FIFO_DEPTH,
   parameter int unsigned ADDR_W   = DMA_FIFO_ADDR_W,
   parameter int unsigned AF_LEVEL = DMA_FIFO_AF_LEVEL,
   parameter int unsigned AE_LEVEL = DMA_FIFO_AE_LEVEL
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              fifo_write,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_read,
   output logic [DATA_W-1:0] data_out,
   output logic              data_out_valid,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] FullLvl = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] AfLvl   = (ADDR_W+1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AeLvl   = (ADDR_W+1)'(AE_LEVEL);

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              af_q, af_d;
   logic              ae_q, ae_d;
   logic              valid_q, valid_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              rd_ok, wr_ok;
   logic              mem_we, mem_re;

   always_comb begin
      rd_ok    = fifo_read & ~empty_q;
      // A full FIFO still takes a push when the same cycle pops a word out.
      wr_ok    = fifo_write & (~full_q | rd_ok);
      mem_we   = wr_ok & ~flush;
      mem_re   = rd_ok & ~flush;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      valid_d  = 1'b0;
      ovf_d    = ovf_q;
      unf_d    = unf_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
         end
         unique case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
         endcase
         valid_d = rd_ok;
         ovf_d   = ovf_q | (fifo_write & ~wr_ok);
         unf_d   = unf_q | (fifo_read & empty_q);
      end

      full_d  = (level_d == FullLvl);
      empty_d = (level_d == '0);
      af_d    = (level_d >= AfLvl);
      ae_d    = (level_d <= AeLvl);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   dma_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (mem_we),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (mem_re),
      .rd_addr (rd_ptr_q),
      .rd_data (data_out)
   );

   assign data_out_valid = valid_q;
   assign fifo_full      = full_q;
   assign fifo_empty     = empty_q;
   assign almost_full    = af_q;
   assign almost_empty   = ae_q;
   assign level          = level_q;
   assign overflow       = ovf_q;
   assign underflow      = unf_q;

endmodule
